// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder. A start pulse in IDLE captures both operands and
// the carry-in; the sum is then formed one bit per clock, LSB first, using two
// chained half-adder slices with the running carry held in a flip-flop. The
// partial result builds up in a shadow shift register, so sum/cout change only
// once, when the last bit has been added and done pulses.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   Adds a 'sub' input. With sub=1 the B operand is inverted and the carry
//   flop is forced to 1, giving sum = a - b (cout=1 means no borrow).
//
// Parameters
//   WIDTH  operand and sum width in bits (2..32)
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request, sampled only when not busy
//   a, b   operands, captured on an accepted start
//   cin    carry-in, captured on an accepted start
//   sub    (SERIAL_ADDER_SUB_EN only) subtract select, captured with operands
//   busy   high while bits are being added
//   done   one-cycle pulse when sum/cout are valid
//   sum    result, held until the next result is delivered
//   cout   final carry, held with sum
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  // Operand values as loaded on an accepted start.
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Two chained half-adder slices on the current LSBs.
  logic ha0_s, ha0_c;
  logic ha1_s, ha1_c;
  logic bit_sum;
  logic bit_carry;

  // NOTE: every signal driven from always_comb gets a value on every path
  // (defaults first) so no latch is inferred.
  always_comb begin
    b_load = b;
    c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load = ~b;
      c_load = 1'b1;
    end
`endif
    ha0_s     = a_sh[0] ^ b_sh[0];
    ha0_c     = a_sh[0] & b_sh[0];
    ha1_s     = ha0_s ^ carry;
    ha1_c     = ha0_s & carry;
    bit_sum   = ha1_s;
    bit_carry = ha0_c | ha1_c;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, not just control, so an
      // aborted operation leaves no stale partial result behind.
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE lasts exactly one cycle and then behaves as IDLE; its exit edge
        // is already an IDLE sampling point, which gives the WIDTH+1 cycle
        // throughput when start is held high.
        IDLE, DONE: begin
          busy <= start;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= bit_carry;
          res_sh <= {bit_sum, res_sh[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            sum   <= {bit_sum, res_sh[WIDTH-1:1]};
            cout  <= bit_carry;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Directed self-checking bench for serial_adder (WIDTH=8). Each scenario task
// drives its own stimulus and compares outputs against hand-computed values.
// Inputs change and outputs are sampled on the falling clock edge.
// Build with SERIAL_ADDER_SUB_EN defined to also exercise subtraction.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub   = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance falling edges until done is seen (current sample included).
  // Returns number of busy samples seen and whether done arrived in time.
  task automatic wait_done(output int busy_cnt, output bit ok);
    busy_cnt = 0;
    ok       = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  // Issue one start, then check cycle count, result and pulse width.
  task automatic run_op(input string name, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic cv,
                        input logic [W-1:0] exp_sum, input logic exp_cout);
    int busy_cnt;
    bit ok;
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~av; b = ~bv; cin = ~cv;  // operands may change after acceptance
    wait_done(busy_cnt, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: done not seen within 40 cycles", name);
    end
    checks++;
    if (busy_cnt !== W) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d expected %0d", name, busy_cnt, W);
    end
    checks++;
    if (sum !== exp_sum || cout !== exp_cout) begin
      errors++;
      $display("FAIL %s_result: got cout=%b sum=%h expected cout=%b sum=%h",
               name, cout, sum, exp_cout, exp_sum);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: got done=%b busy=%b expected done=0 busy=0",
               name, done, busy);
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b sum=%h cout=%b expected 0 0 00 0",
               busy, done, sum, cout);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_op("basic", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
  endtask

  task automatic test_carry();
    run_op("ff_plus_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("ff_ff_cin", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_op("cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
  endtask

  task automatic test_back_to_back();
    int busy_cnt;
    bit ok;
    int t1;
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    wait_done(busy_cnt, ok);
    t1 = cyc;
    checks++;
    if (!ok || sum !== 8'h03 || cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got ok=%b sum=%h cout=%b expected 1 03 0", ok, sum, cout);
    end
    a = 8'h70; b = 8'h94; cin = 1'b1;  // taken at the DONE exit edge
    @(negedge clk);
    start = 1'b0;
    wait_done(busy_cnt, ok);
    checks++;
    if (!ok || (cyc - t1) !== 9) begin
      errors++;
      $display("FAIL b2b_period: got ok=%b period=%0d expected 9", ok, cyc - t1);
    end
    checks++;
    if (sum !== 8'h05 || cout !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got sum=%h cout=%b expected 05 1", sum, cout);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_ignore_start();
    int busy_cnt;
    bit ok;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h01; b = 8'h01; start = 1'b1;  // during RUN: must be ignored
    @(negedge clk);
    start = 1'b0;
    wait_done(busy_cnt, ok);
    checks++;
    if (!ok || sum !== 8'h46 || cout !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_result: got ok=%b sum=%h cout=%b expected 1 46 0",
               ok, sum, cout);
    end
    // Not queued, and the result holds while idle.
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_queued: got busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (sum !== 8'h46 || cout !== 1'b0) begin
      errors++;
      $display("FAIL sum_hold: got sum=%h cout=%b expected 46 0", sum, cout);
    end
  endtask

  task automatic test_reset_midop();
    int done_seen = 0;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk);            // RUN cycle 1
    start = 1'b0;
    repeat (3) @(negedge clk); // RUN cycle 4
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: got busy=%b done=%b sum=%h cout=%b expected 0 0 00 0",
               busy, done, sum, cout);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL midop_no_done: got %0d done pulses expected 0", done_seen);
    end
    run_op("after_reset", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    sub = 1'b1;
    run_op("sub_borrow", 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0);
    run_op("sub_no_borrow", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
    sub = 1'b0;
    run_op("sub_off_add", 8'h07, 8'h05, 1'b0, 8'h0C, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_ignore_start();
    test_reset_midop();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
